// File: rtl/uart_rx.sv
// 8N1 UART receiver with x16 oversampling, a selectable divisor, and a single-entry output holding register.
// The register reports framing and overrun errors. After a stop bit sampled low, the receiver waits in BREAK until the line returns high.
module uart_rx #(
  parameter int DIV0 = 651,
  parameter int DIV1 = 326,
  parameter int DIV2 = 163,
  parameter int DIV3 = 109
) (
  input  logic       system_clk,
  input  logic       reset_n,
  input  logic [1:0] baud_config,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       framing_error,
  output logic       overrun_error,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] div_q, div_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        deliver_q, deliver_d;
  logic        stop_bit_q, stop_bit_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        fe_q, fe_d;
  logic        ovr_q, ovr_d;
  logic        rx_s;
  logic        tick;

  function automatic logic [15:0] sel_div(input logic [1:0] cfg);
    case (cfg)
      2'b00:   sel_div = 16'(DIV0);
      2'b01:   sel_div = 16'(DIV1);
      2'b10:   sel_div = 16'(DIV2);
      default: sel_div = 16'(DIV3);
    endcase
  endfunction

  assign rx_s = sync2_q;
  assign tick = (state_q != IDLE) && (tick_cnt_q == div_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    deliver_d  = 1'b0;
    stop_bit_d = stop_bit_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    fe_d       = fe_q;
    ovr_d      = ovr_q;

    if (state_q == IDLE || tick) tick_cnt_d = 16'd0;
    else                         tick_cnt_d = tick_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          div_d      = sel_div(baud_config);
          samp_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      START: begin
        // Mid-bit check rejects glitches shorter than half a bit
        if (tick) begin
          if (samp_cnt_q == 4'd7) begin
            samp_cnt_d = 4'd0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_cnt_q == 4'd15) begin
            samp_cnt_d = 4'd0;
            shift_d    = {rx_s, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (samp_cnt_q == 4'd15) begin
            samp_cnt_d = 4'd0;
            deliver_d  = 1'b1;
            stop_bit_d = rx_s;
            state_d    = rx_s ? IDLE : BREAK;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An acknowledge in the delivery cycle frees the holding register for the new byte
    if (deliver_q) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        fe_d       = ~stop_bit_q;
        if (rx_ack) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      div_q      <= 16'(DIV0);
      tick_cnt_q <= 16'd0;
      samp_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      deliver_q  <= 1'b0;
      stop_bit_q <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= rx_serial;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      deliver_q  <= deliver_d;
      stop_bit_q <= stop_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign framing_error = fe_q;
  assign overrun_error = ovr_q;
  assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DIV3=4 (one bit = 64 clocks).
// It uses table-driven frames plus hand sequences for the glitch, break, overrun, coincident-ack and mid-frame reset cases.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] baud_config;
  logic       rx_serial;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun_error;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  uart_rx #(.DIV3(4)) dut (
    .system_clk    (clk),
    .reset_n       (reset_n),
    .baud_config   (baud_config),
    .rx_serial     (rx_serial),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         chg_baud;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " rx_data"},       32'(rx_data),       32'h00);
    check({tag, " rx_valid"},      32'(rx_valid),      32'h0);
    check({tag, " framing_error"}, 32'(framing_error), 32'h0);
    check({tag, " overrun_error"}, 32'(overrun_error), 32'h0);
    check({tag, " rx_busy"},       32'(rx_busy),       32'h0);
  endtask

  // Cycle c of a frame is driven on the negedge following posedge c; the ack at c=611 lands on the delivery edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at,
                            input int rst_at, input bit chg_baud);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    @(negedge clk);
    rx_serial = fr[0];
    for (int c = 1; c < 640; c++) begin
      @(negedge clk);
      rx_serial = fr[c / 64];
      rx_ack    = (c == ack_at);
      if (chg_baud && c == 100) baud_config = 2'b00;
      if (c == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid-frame reset");
      end
      if (c == rst_at + 2) reset_n = 1'b1;
    end
    @(negedge clk);
    rx_ack      = 1'b0;
    baud_config = 2'b11;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 8'hA5, chg_baud: 1'b0, exp_data: 8'hA5, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h00, chg_baud: 1'b0, exp_data: 8'h00, exp_fe: 1'b0};
    vecs[2] = '{data: 8'hFF, chg_baud: 1'b0, exp_data: 8'hFF, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h5A, chg_baud: 1'b1, exp_data: 8'h5A, exp_fe: 1'b0};
    vecs[4] = '{data: 8'h80, chg_baud: 1'b0, exp_data: 8'h80, exp_fe: 1'b0};
    vecs[5] = '{data: 8'h01, chg_baud: 1'b1, exp_data: 8'h01, exp_fe: 1'b0};

    reset_n     = 1'b0;
    baud_config = 2'b11;
    rx_serial   = 1'b1;
    rx_ack      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("after release");

    // Good frames, each acknowledged.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, 1'b1, -1, -1, vecs[i].chg_baud);
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'h1);
      check($sformatf("vec%0d framing_error", i), 32'(framing_error), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d rx_busy", i), 32'(rx_busy), 32'h0);
      pulse_ack();
      check($sformatf("vec%0d ack rx_valid", i), 32'(rx_valid), 32'h0);
      check($sformatf("vec%0d ack rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
    end

    // Start-bit glitch: line low for 20 cycles.
    @(negedge clk);
    rx_serial = 1'b0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      if (c == 20) rx_serial = 1'b1;
      if (c == 10) check("glitch busy during start", 32'(rx_busy), 32'h1);
    end
    check("glitch rx_busy", 32'(rx_busy), 32'h0);
    check("glitch rx_valid", 32'(rx_valid), 32'h0);
    check("glitch framing_error", 32'(framing_error), 32'h0);
    check("glitch overrun_error", 32'(overrun_error), 32'h0);

    // Break: stop bit low, line held low.
    send_frame(8'h3C, 1'b0, -1, -1, 1'b0);
    check("break rx_data", 32'(rx_data), 32'h3C);
    check("break rx_valid", 32'(rx_valid), 32'h1);
    check("break framing_error", 32'(framing_error), 32'h1);
    check("break rx_busy", 32'(rx_busy), 32'h1);
    repeat (150) @(negedge clk);
    check("break busy held", 32'(rx_busy), 32'h1);
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    check("break busy released", 32'(rx_busy), 32'h0);
    check("break no redelivery", 32'(rx_data), 32'h3C);
    pulse_ack();
    check("break ack rx_valid", 32'(rx_valid), 32'h0);

    // Overrun.
    send_frame(8'h11, 1'b1, -1, -1, 1'b0);
    send_frame(8'h22, 1'b1, -1, -1, 1'b0);
    check("overrun rx_data", 32'(rx_data), 32'h11);
    check("overrun rx_valid", 32'(rx_valid), 32'h1);
    check("overrun flag", 32'(overrun_error), 32'h1);
    check("overrun framing_error", 32'(framing_error), 32'h0);
    pulse_ack();
    check("overrun ack rx_valid", 32'(rx_valid), 32'h0);
    check("overrun ack flag", 32'(overrun_error), 32'h0);

    // Ack coincident with delivery of the second byte.
    send_frame(8'h44, 1'b1, -1, -1, 1'b0);
    check("coinc first rx_data", 32'(rx_data), 32'h44);
    send_frame(8'h55, 1'b1, 611, -1, 1'b0);
    check("coinc rx_data", 32'(rx_data), 32'h55);
    check("coinc rx_valid", 32'(rx_valid), 32'h1);
    check("coinc overrun_error", 32'(overrun_error), 32'h0);

    // Reset pulse during data bit 4 of 8'hFF; valid byte 8'h55 still pending.
    send_frame(8'hFF, 1'b1, -1, 350, 1'b0);
    check("post-reset no delivery", 32'(rx_valid), 32'h0);
    check("post-reset rx_data", 32'(rx_data), 32'h00);
    send_frame(8'h81, 1'b1, -1, -1, 1'b0);
    check("after reset rx_data", 32'(rx_data), 32'h81);
    check("after reset rx_valid", 32'(rx_valid), 32'h1);
    check("after reset framing_error", 32'(framing_error), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DIV0, default 651, tick divisor for baud_config 2'b00 (9600 bps x16 at 100 MHz).
REQ-002 SHALL provide parameter DIV1, default 326, tick divisor for baud_config 2'b01 (19200 bps x16).
REQ-003 SHALL provide parameter DIV2, default 163, tick divisor for baud_config 2'b10 (38400 bps x16).
REQ-004 SHALL provide parameter DIV3, default 109, tick divisor for baud_config 2'b11 (57600 bps x16).
REQ-005 SHALL provide port system_clk, input, 1, rising-edge clock.
REQ-006 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide port baud_config, input, 2, selects DIV0..DIV3.
REQ-008 SHALL provide port rx_serial, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL provide port rx_ack, input, 1, consumer acknowledge of rx_data.
REQ-010 SHALL provide port rx_data, output, 8, last received byte.
REQ-011 SHALL provide port rx_valid, output, 1, rx_data holds an unacknowledged byte.
REQ-012 SHALL provide port framing_error, output, 1, stop bit of byte in rx_data sampled low.
REQ-013 SHALL provide port overrun_error, output, 1, sticky; a byte was dropped.
REQ-014 SHALL provide port rx_busy, output, 1, high whenever FSM is not IDLE.

Function
REQ-015 rx_serial SHALL pass through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value.
REQ-016 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-017 Divisor SHALL be latched from baud_config on leaving IDLE; baud_config changes mid-frame SHALL have no effect.
REQ-018 Tick counter SHALL be held at 0 in IDLE, count 0..DIV-1 otherwise, asserting one-cycle tick at DIV-1 then wrapping to 0.
REQ-019 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-020 IDLE -> START on synchronized line low; tick and sample counters cleared.
REQ-021 START: on 8th tick sample line; high -> IDLE, no flags, no output (glitch); low -> DATA, sample counter cleared.
REQ-022 DATA: every 16th tick sample one bit into shift register MSB, shifting right; after 8th bit -> STOP.
REQ-023 STOP: on 16th tick sample stop bit and deliver byte (REQ-025); sample 1 -> IDLE; sample 0 -> BREAK.
REQ-024 BREAK: remain until synchronized line is high, then -> IDLE; no further deliveries during BREAK.
REQ-025 Delivery, in the cycle after the stop-sample tick: if rx_valid=0 or rx_ack=1, load rx_data, set rx_valid=1, set framing_error=NOT stop sample; otherwise keep rx_data/framing_error unchanged and set overrun_error=1.
REQ-026 rx_ack with rx_valid=1 and no same-cycle delivery SHALL clear rx_valid next cycle; rx_data holds its value.
REQ-027 rx_ack coincident with delivery SHALL load new byte, keep rx_valid=1, and not set overrun_error.
REQ-028 overrun_error SHALL clear on any cycle rx_ack=1 unless set in that same cycle.
REQ-029 rx_ack with rx_valid=0 SHALL have no effect.
REQ-030 rx_busy SHALL be combinational from FSM state (0 only in IDLE).

Reset
REQ-031 reset_n low SHALL asynchronously force: FSM IDLE, counters 0, shift register 0, rx_data 8'h00, rx_valid 0, framing_error 0, overrun_error 0, rx_busy 0, synchronizer 1s.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no delivery; after release the next falling edge starts a fresh frame.

Verification (DIV3=4, baud_config=2'b11, bit = 64 cycles)
REQ-033 Send 8'hA5 with valid stop -> rx_valid=1 with rx_data=8'hA5, framing_error=0; rx_ack clears rx_valid next cycle.
REQ-034 Line low for 20 cycles then high -> returns to IDLE, rx_valid stays 0, no error flags.
REQ-035 Send 8'h3C with stop bit 0, hold line low 200 cycles -> rx_data=8'h3C, framing_error=1, rx_busy=1 until line high, then 0.
REQ-036 Send 8'h11 then 8'h22 without rx_ack -> rx_data=8'h11, overrun_error=1; rx_ack clears both rx_valid and overrun_error.
REQ-037 Assert rx_ack in the exact cycle the second byte 8'h55 is delivered -> rx_data=8'h55, rx_valid=1, overrun_error=0.
REQ-038 Pulse reset_n low during DATA bit 4 of 8'hFF -> all outputs at reset values; next frame 8'h81 received correctly.
